// File: rtl/rtype_ctrl_pkg.sv
// Shared definitions for the multicycle R-type controller.
// Contents: FSM state encodings, ALU operation codes, opcode and funct
// constants, and select encodings for pc_src and alu_src_b.
package rtype_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_WB     = 3'd4,
    ST_BRANCH = 3'd5,
    ST_HALT   = 3'd7
  } state_e;

  // ALU operation codes
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  // Opcodes
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;

  // Funct fields
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_NOR = 6'b100111;

  // pc_src selects
  localparam logic [1:0] PC_SRC_ALU = 2'b00;
  localparam logic [1:0] PC_SRC_BR  = 2'b01;

  // alu_src_b selects
  localparam logic [1:0] SRC_B_RT    = 2'b00;
  localparam logic [1:0] SRC_B_FOUR  = 2'b01;
  localparam logic [1:0] SRC_B_BROFF = 2'b11;

endpackage

// File: rtl/rtype_alu_decoder.sv
// Combinational funct -> ALU control decoder.
// Ports:
//   funct   [5:0] in  : R-type funct field
//   alu_ctl [3:0] out : ALU operation code (ADD when funct is unsupported)
//   valid         out : 1 when funct is a supported operation
module rtype_alu_decoder
  import rtype_ctrl_pkg::*;
(
  input  logic [5:0] funct,
  output logic [3:0] alu_ctl,
  output logic       valid
);

  always_comb begin
    alu_ctl = ALU_ADD;
    valid   = 1'b1;
    case (funct)
      FN_ADD:  alu_ctl = ALU_ADD;
      FN_SUB:  alu_ctl = ALU_SUB;
      FN_AND:  alu_ctl = ALU_AND;
      FN_OR:   alu_ctl = ALU_OR;
      FN_SLT:  alu_ctl = ALU_SLT;
      FN_NOR:  alu_ctl = ALU_NOR;
      default: valid   = 1'b0;
    endcase
  end

endmodule

// File: rtl/rtype_mc_controller.sv
// Multicycle control FSM for the R-type datapath: fetch, decode, execute,
// write-back, with BEQ and NOP support and a sticky HALT trap for
// undecodable instructions.
// Ports:
//   clk, reset (async, active-high)
//   run        : keep issuing instructions; 0 parks in IDLE at a boundary
//   instr[31:0]: instruction register from datapath
//   zf         : ALU zero flag
//   pc_write, pc_src[1:0], ir_write, reg_write, alu_src_a, alu_src_b[1:0],
//   alu_ctl[3:0] : datapath controls
//   illegal    : sticky trap flag (set while in HALT)
//   state[2:0] : current FSM state (debug)
// Optional: define RTYPE_CTRL_PERF_CNT_EN to add cycle_cnt[31:0] and
//   retired_cnt[31:0] performance counters.
module rtype_mc_controller
  import rtype_ctrl_pkg::*;
#(
  parameter logic [1:0] FETCH_PC_INC  = SRC_B_FOUR,
  parameter logic [1:0] BR_OFFSET_SEL = SRC_B_BROFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic [31:0] instr,
  input  logic        zf,
  output logic        pc_write,
  output logic [1:0]  pc_src,
  output logic        ir_write,
  output logic        reg_write,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [3:0]  alu_ctl,
  output logic        illegal,
  output logic [2:0]  state
`ifdef RTYPE_CTRL_PERF_CNT_EN
  ,
  output logic [31:0] cycle_cnt,
  output logic [31:0] retired_cnt
`endif
);

  state_e     state_q, state_d;
  logic [3:0] dec_ctl;
  logic       dec_valid;
  logic       is_nop;
  logic       retire;

  rtype_alu_decoder u_dec (
    .funct   (instr[5:0]),
    .alu_ctl (dec_ctl),
    .valid   (dec_valid)
  );

  assign is_nop = (instr == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    pc_write  = 1'b0;
    pc_src    = PC_SRC_ALU;
    ir_write  = 1'b0;
    reg_write = 1'b0;
    alu_src_a = 1'b0;
    alu_src_b = SRC_B_RT;
    alu_ctl   = ALU_ADD;
    case (state_q)
      ST_IDLE: begin
        if (run) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        ir_write  = 1'b1;
        pc_write  = 1'b1;
        alu_src_b = FETCH_PC_INC;
        state_d   = ST_DECODE;
      end
      ST_DECODE: begin
        alu_src_b = BR_OFFSET_SEL;
        // NOP must be checked first: all-zero is opcode 0 with an invalid funct
        if (is_nop)                                 state_d = run ? ST_FETCH : ST_IDLE;
        else if (instr[31:26] == OP_RTYPE && dec_valid) state_d = ST_EXEC;
        else if (instr[31:26] == OP_BEQ)            state_d = ST_BRANCH;
        else                                        state_d = ST_HALT;
      end
      ST_EXEC: begin
        alu_src_a = 1'b1;
        alu_ctl   = dec_ctl;
        state_d   = ST_WB;
      end
      ST_WB: begin
        alu_src_a = 1'b1;
        alu_ctl   = dec_ctl;
        reg_write = 1'b1;
        state_d   = run ? ST_FETCH : ST_IDLE;
      end
      ST_BRANCH: begin
        alu_src_a = 1'b1;
        alu_ctl   = ALU_SUB;
        pc_write  = zf;
        pc_src    = PC_SRC_BR;
        state_d   = run ? ST_FETCH : ST_IDLE;
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IDLE;
    endcase
  end

  assign illegal = (state_q == ST_HALT);
  assign state   = state_q;
  assign retire  = (state_q == ST_WB) || (state_q == ST_BRANCH) ||
                   (state_q == ST_DECODE && is_nop);

`ifdef RTYPE_CTRL_PERF_CNT_EN
  logic [31:0] cycle_cnt_q, cycle_cnt_d;
  logic [31:0] retired_cnt_q, retired_cnt_d;

  always_comb begin
    cycle_cnt_d   = cycle_cnt_q;
    retired_cnt_d = retired_cnt_q;
    if (state_q != ST_IDLE && state_q != ST_HALT) cycle_cnt_d = cycle_cnt_q + 32'd1;
    if (retire) retired_cnt_d = retired_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_cnt_q   <= '0;
      retired_cnt_q <= '0;
    end else begin
      cycle_cnt_q   <= cycle_cnt_d;
      retired_cnt_q <= retired_cnt_d;
    end
  end

  assign cycle_cnt   = cycle_cnt_q;
  assign retired_cnt = retired_cnt_q;
`else
  logic unused_retire;
  assign unused_retire = retire;
`endif

endmodule

// File: tb/tb_rtype_mc_controller.sv
module tb_rtype_mc_controller;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        run = 1'b0;
  logic [31:0] instr = 32'h0;
  logic        zf = 1'b0;
  logic        pc_write, ir_write, reg_write, alu_src_a, illegal;
  logic [1:0]  pc_src, alu_src_b;
  logic [3:0]  alu_ctl;
  logic [2:0]  state;
`ifdef RTYPE_CTRL_PERF_CNT_EN
  logic [31:0] cycle_cnt, retired_cnt;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  rtype_mc_controller dut (
    .clk       (clk),
    .reset     (reset),
    .run       (run),
    .instr     (instr),
    .zf        (zf),
    .pc_write  (pc_write),
    .pc_src    (pc_src),
    .ir_write  (ir_write),
    .reg_write (reg_write),
    .alu_src_a (alu_src_a),
    .alu_src_b (alu_src_b),
    .alu_ctl   (alu_ctl),
    .illegal   (illegal),
    .state     (state)
`ifdef RTYPE_CTRL_PERF_CNT_EN
    ,
    .cycle_cnt   (cycle_cnt),
    .retired_cnt (retired_cnt)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    run   = 1'b0;
    zf    = 1'b0;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (state !== 3'd0 || pc_write !== 1'b0 || ir_write !== 1'b0 || reg_write !== 1'b0 ||
        illegal !== 1'b0 || pc_src !== 2'b00 || alu_src_a !== 1'b0 ||
        alu_src_b !== 2'b00 || alu_ctl !== 4'b0010) begin
      errors++;
      $display("FAIL reset_state: st=%0d pcw=%b irw=%b rw=%b ill=%b pcs=%b a=%b b=%b ctl=%b required 0 0 0 0 0 00 0 00 0010",
               state, pc_write, ir_write, reg_write, illegal, pc_src, alu_src_a, alu_src_b, alu_ctl);
    end
    step();
    reset = 1'b0;
    step();
    checks++;
    if (state !== 3'd0) begin errors++; $display("FAIL idle_hold: state=%0d required 0", state); end
  endtask

  task automatic test_rtype_add();
    logic [2:0] exp_st [5] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd1};
    logic       exp_rw [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    do_reset();
    instr = 32'h00221820;
    run   = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (state !== exp_st[i]) begin
        errors++; $display("FAIL add_state[%0d]: state=%0d required %0d", i, state, exp_st[i]);
      end
      checks++;
      if (reg_write !== exp_rw[i]) begin
        errors++; $display("FAIL add_reg_write[%0d]: got %b required %b", i, reg_write, exp_rw[i]);
      end
      if (i == 0) begin
        checks++;
        if (ir_write !== 1'b1 || pc_write !== 1'b1 || alu_src_b !== 2'b01 || pc_src !== 2'b00) begin
          errors++; $display("FAIL add_fetch: irw=%b pcw=%b b=%b pcs=%b required 1 1 01 00",
                             ir_write, pc_write, alu_src_b, pc_src);
        end
      end
      if (i == 1) begin
        checks++;
        if (alu_src_a !== 1'b0 || alu_src_b !== 2'b11 || alu_ctl !== 4'b0010 || ir_write !== 1'b0) begin
          errors++; $display("FAIL add_decode: a=%b b=%b ctl=%b irw=%b required 0 11 0010 0",
                             alu_src_a, alu_src_b, alu_ctl, ir_write);
        end
      end
      if (i == 2 || i == 3) begin
        checks++;
        if (alu_ctl !== 4'b0010 || alu_src_a !== 1'b1 || alu_src_b !== 2'b00) begin
          errors++; $display("FAIL add_exec_wb[%0d]: ctl=%b a=%b b=%b required 0010 1 00",
                             i, alu_ctl, alu_src_a, alu_src_b);
        end
      end
    end
  endtask

  task automatic test_funct_table();
    logic [5:0] fn  [6] = '{6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b100111, 6'b100000};
    logic [3:0] ctl [6] = '{4'b0110, 4'b0000, 4'b0001, 4'b0111, 4'b1100, 4'b0010};
    for (int i = 0; i < 6; i++) begin
      do_reset();
      instr = {6'b000000, 5'd1, 5'd2, 5'd3, 5'd0, fn[i]};
      run   = 1'b1;
      step(); step(); step();
      checks++;
      if (state !== 3'd3 || alu_ctl !== ctl[i]) begin
        errors++; $display("FAIL funct_exec[%0d]: state=%0d ctl=%b required 3 %b", i, state, alu_ctl, ctl[i]);
      end
      step();
      checks++;
      if (state !== 3'd4 || alu_ctl !== ctl[i]) begin
        errors++; $display("FAIL funct_wb[%0d]: state=%0d ctl=%b required 4 %b", i, state, alu_ctl, ctl[i]);
      end
    end
    do_reset();
    instr = 32'h00221801;
    run   = 1'b1;
    step(); step(); step();
    checks++;
    if (state !== 3'd7 || illegal !== 1'b1) begin
      errors++; $display("FAIL bad_funct: state=%0d illegal=%b required 7 1", state, illegal);
    end
  endtask

  task automatic test_beq();
    logic zv [2] = '{1'b1, 1'b0};
    for (int i = 0; i < 2; i++) begin
      do_reset();
      instr = 32'h10220003;
      run   = 1'b1;
      step(); step();
      zf = zv[i];
      step();
      checks++;
      if (state !== 3'd5 || pc_write !== zv[i] || pc_src !== 2'b01 || alu_ctl !== 4'b0110 ||
          alu_src_a !== 1'b1 || alu_src_b !== 2'b00 || reg_write !== 1'b0) begin
        errors++; $display("FAIL beq_branch[zf=%b]: st=%0d pcw=%b pcs=%b ctl=%b a=%b b=%b rw=%b required 5 %b 01 0110 1 00 0",
                           zv[i], state, pc_write, pc_src, alu_ctl, alu_src_a, alu_src_b, reg_write, zv[i]);
      end
      zf = ~zv[i];
      #1;
      checks++;
      if (pc_write !== ~zv[i]) begin
        errors++; $display("FAIL beq_zf_comb: pc_write=%b required %b", pc_write, ~zv[i]);
      end
      step();
      checks++;
      if (state !== 3'd1) begin errors++; $display("FAIL beq_return: state=%0d required 1", state); end
    end
  endtask

  task automatic test_illegal();
    do_reset();
    instr = 32'h8C220000;
    run   = 1'b1;
    step(); step(); step();
    checks++;
    if (state !== 3'd7 || illegal !== 1'b1 || pc_write !== 1'b0 || ir_write !== 1'b0 || reg_write !== 1'b0) begin
      errors++; $display("FAIL lw_halt: state=%0d illegal=%b required 7 1 with no strobes", state, illegal);
    end
    for (int i = 0; i < 10; i++) begin
      run = ~run;
      step();
      checks++;
      if (state !== 3'd7 || illegal !== 1'b1) begin
        errors++; $display("FAIL halt_sticky[%0d]: state=%0d illegal=%b required 7 1", i, state, illegal);
      end
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (state !== 3'd0 || illegal !== 1'b0) begin
      errors++; $display("FAIL halt_reset: state=%0d illegal=%b required 0 0", state, illegal);
    end
    run = 1'b0;
    step();
    reset = 1'b0;
  endtask

  task automatic test_async_reset();
    do_reset();
    instr = 32'h00221820;
    run   = 1'b1;
    step(); step(); step();
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (state !== 3'd0 || reg_write !== 1'b0) begin
      errors++; $display("FAIL async_reset: state=%0d reg_write=%b required 0 0", state, reg_write);
    end
    step();
    checks++;
    if (state !== 3'd0 || reg_write !== 1'b0) begin
      errors++; $display("FAIL async_no_wb: state=%0d reg_write=%b required 0 0", state, reg_write);
    end
    reset = 1'b0;
    step();
    checks++;
    if (state !== 3'd1) begin errors++; $display("FAIL async_restart: state=%0d required 1", state); end
  endtask

  task automatic test_run_drop();
    int bad_irw;
    do_reset();
    instr = 32'h00221820;
    run   = 1'b1;
    step(); step(); step();
    run = 1'b0;
    step();
    checks++;
    if (state !== 3'd4 || reg_write !== 1'b1) begin
      errors++; $display("FAIL drop_wb: state=%0d reg_write=%b required 4 1", state, reg_write);
    end
    bad_irw = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (state !== 3'd0 || ir_write !== 1'b0) bad_irw++;
    end
    checks++;
    if (bad_irw != 0) begin
      errors++; $display("FAIL drop_idle: %0d bad idle cycles, required 0 (last state=%0d)", bad_irw, state);
    end
    run = 1'b1;
    step();
    checks++;
    if (state !== 3'd1 || ir_write !== 1'b1) begin
      errors++; $display("FAIL drop_rerun: state=%0d ir_write=%b required 1 1", state, ir_write);
    end
  endtask

  task automatic test_back_to_back();
    // NOP with run=1: FETCH, DECODE, FETCH with no idle bubble
    do_reset();
    instr = 32'h0;
    run   = 1'b1;
    step(); step();
    checks++;
    if (state !== 3'd2) begin errors++; $display("FAIL nop_decode: state=%0d required 2", state); end
    step();
    checks++;
    if (state !== 3'd1) begin errors++; $display("FAIL nop_b2b: state=%0d required 1", state); end
    run = 1'b0;
    step(); step();
    checks++;
    if (state !== 3'd0) begin errors++; $display("FAIL nop_park: state=%0d required 0", state); end
  endtask

`ifdef RTYPE_CTRL_PERF_CNT_EN
  task automatic test_perf_cnt();
    do_reset();
    checks++;
    if (cycle_cnt !== 32'd0 || retired_cnt !== 32'd0) begin
      errors++; $display("FAIL perf_reset: cyc=%0d ret=%0d required 0 0", cycle_cnt, retired_cnt);
    end
    instr = 32'h00221820;
    run   = 1'b1;
    step(); step(); step(); step();
    instr = 32'h0;
    step(); step(); step();
    instr = 32'h10220003;
    step(); step();
    run = 1'b0;
    step(); step(); step();
    checks++;
    if (state !== 3'd0 || cycle_cnt !== 32'd9 || retired_cnt !== 32'd3) begin
      errors++; $display("FAIL perf_counts: state=%0d cyc=%0d ret=%0d required 0 9 3", state, cycle_cnt, retired_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_rtype_add();
    test_funct_table();
    test_beq();
    test_illegal();
    test_async_reset();
    test_run_drop();
    test_back_to_back();
`ifdef RTYPE_CTRL_PERF_CNT_EN
    test_perf_cnt();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rtype_mc_controller.md
Name: rtype_mc_controller

Overview:
- Multicycle control FSM that sequences the R-type datapath (DPTR) one instruction at a time: fetch, decode, execute, write-back.
- Supports R-type ALU ops, BEQ (using the datapath zero flag) and NOP.
- Traps undecodable instructions into a sticky HALT state.
- Sits beside the datapath at top level: consumes its instruction register and ZF, drives all its write strobes and mux selects.

Parameters:
- FETCH_PC_INC, 2'b01, alu_src_b select meaning "constant 4".
- BR_OFFSET_SEL, 2'b11, alu_src_b select meaning "sign-extended imm << 2".

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- run  input  1  1 = keep issuing instructions; 0 = park in IDLE at the next instruction boundary.
- instr  input  32  datapath instruction register output; valid from DECODE onward.
- zf  input  1  ALU zero flag from datapath.
- pc_write  output  1  PC register load enable.
- pc_src  output  2  00 = ALU result (PC+4), 01 = branch target register.
- ir_write  output  1  instruction register load enable.
- reg_write  output  1  register-file write enable.
- alu_src_a  output  1  0 = PC, 1 = rs.
- alu_src_b  output  2  00 = rt, 01 = const 4, 11 = branch offset.
- alu_ctl  output  4  ALU operation code.
- illegal  output  1  sticky trap flag.
- state  output  3  current FSM state, for debug.

Behaviour:
- Reset (async, any state, mid-instruction included): state = IDLE; all strobes 0; pc_src = 00, alu_src_a = 0, alu_src_b = 00, alu_ctl = 0010, illegal = 0.
- States and encodings: IDLE = 0, FETCH = 1, DECODE = 2, EXEC = 3, WB = 4, BRANCH = 5, HALT = 7.
- IDLE: no strobes. Goes to FETCH when run = 1.
- FETCH (1 cycle):
  - ir_write = 1, pc_write = 1, pc_src = 00.
  - alu_src_a = 0, alu_src_b = 01, alu_ctl = ADD.
  - Next state: DECODE.
- DECODE (1 cycle): alu_src_a = 0, alu_src_b = 11, alu_ctl = ADD (computes branch target). Next state:
  - instr == 32'h0 (NOP) → FETCH if run, else IDLE.
  - opcode 000000 with a supported funct → EXEC.
  - opcode 000100 (BEQ) → BRANCH.
  - anything else → HALT.
- EXEC (1 cycle): alu_src_a = 1, alu_src_b = 00, alu_ctl = decode(funct). Next state: WB.
- WB (1 cycle): reg_write = 1; alu_ctl and selects held equal to EXEC values. Next state: FETCH if run, else IDLE.
- BRANCH (1 cycle):
  - alu_src_a = 1, alu_src_b = 00, alu_ctl = SUB.
  - pc_write = zf (combinational on zf in this state only), pc_src = 01.
  - Next state: FETCH if run, else IDLE.
- HALT: illegal = 1; no strobes. run is ignored; only reset exits.
- Funct decode:
  - 100000 → ADD 0010.
  - 100010 → SUB 0110.
  - 100100 → AND 0000.
  - 100101 → OR 0001.
  - 101010 → SLT 0111.
  - 100111 → NOR 1100.
  - Any other funct with opcode 0 → HALT.
- Latency: R-type = 4 cycles, BEQ = 3, NOP = 2.
  - Back-to-back issue with run held at 1 has no idle bubble.
- Output timing: all outputs are Moore, decoded from the registered state. The only exceptions are pc_write in BRANCH and alu_ctl in EXEC/WB, which depend on zf and instr respectively.
- run is sampled only in IDLE, WB, BRANCH and DECODE-NOP. Deasserting run mid-instruction never aborts that instruction.

Optional Feature:
- Macro: RTYPE_CTRL_PERF_CNT_EN.
- Defined: adds output ports cycle_cnt[31:0] and retired_cnt[31:0], both cleared by reset.
  - cycle_cnt increments every cycle while state != IDLE and != HALT.
  - retired_cnt increments on leaving WB, BRANCH, or DECODE for NOP.
  - Both wrap from 32'hFFFFFFFF to 0.
- Undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package rtype_ctrl_pkg holds:
  - state encodings;
  - ALU op codes (ADD/SUB/AND/OR/SLT/NOR);
  - opcode constants (RTYPE = 000000, BEQ = 000100);
  - funct constants;
  - select constants for pc_src and alu_src_b.
- One sub-module, rtype_alu_decoder: combinational funct[5:0] → alu_ctl[3:0] plus a valid bit. The valid bit feeds the DECODE → HALT decision.

Test Plan:
- Reset, then run = 1, instr = 32'h00221820 (add $3,$1,$2):
  - state sequence 0→1→2→3→4→1.
  - reg_write = 1 exactly in cycle 4 only; alu_ctl = 0010 in cycles 3–4; ir_write = 1 and pc_write = 1 in cycle 1.
- instr = 32'h10220003 (beq):
  - with zf = 1 in BRANCH: pc_write = 1, pc_src = 01;
  - repeat with zf = 0: pc_write = 0; returns to FETCH in both cases.
- instr = 32'h8C220000 (lw, unsupported): after DECODE, state = 7 and illegal = 1. Toggling run for 10 cycles leaves it unchanged; reset clears it to IDLE.
- Assert reset asynchronously mid-EXEC (between clock edges): state = 0 and reg_write = 0 immediately, with no WB following.
- Drop run to 0 during EXEC of an add:
  - WB still occurs (reg_write = 1), then state = IDLE with no further ir_write.
  - Re-raising run gives FETCH on the next edge.
- With RTYPE_CTRL_PERF_CNT_EN: run one add, one NOP and one beq, then idle. Expected retired_cnt = 3, cycle_cnt = 9.
